// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: fetch/decode/exec/mem/wb with an optional
// fixed-latency MUL/DIV wait state and a sticky illegal-instruction trap.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   op, funct7_0     instruction bits [6:2] and bit 25 (sampled in DECODE)
//   mem_ready        memory completes the outstanding request this cycle
//   mem_req, mem_we  memory request and its write qualifier
//   ir_write,
//   pc_write         IR / PC load strobes (fetch handshake cycle)
//   branch           branch-resolve strobe (one EXEC cycle)
//   reg_write        register-file write (WB only)
//   mem_to_reg,
//   alu_src, alu_op  datapath controls registered in DECODE
//   state            current FSM state code
//   illegal          sticky illegal-instruction flag
module multicycle_control_unit #(
   parameter int M_EXT       = 1,
   parameter int MUL_LATENCY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] op,
   input  logic       funct7_0,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       ir_write,
   output logic       pc_write,
   output logic       branch,
   output logic       mem_to_reg,
   output logic       alu_src,
   output logic       reg_write,
   output logic [1:0] alu_op,
   output logic [2:0] state,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_MULWAIT = 3'd5,
      S_TRAP    = 3'd6,
      S_BAD     = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      C_ALU    = 2'd0,
      C_LOAD   = 2'd1,
      C_STORE  = 2'd2,
      C_BRANCH = 2'd3
   } cls_t;

   state_t     state_q, state_d;
   cls_t       cls_q, d_cls;
   logic [1:0] alu_op_q, d_alu_op;
   logic       alu_src_q, d_alu_src;
   logic       mtr_q;
   logic       illegal_q;
   logic [3:0] cnt_q;
   logic       legal, d_mul;
   logic       req_c, we_c, irw_c, pcw_c, br_c, rw_c;

   // Opcode decode; ops not listed here are illegal.
   always_comb begin
      legal     = 1'b1;
      d_cls     = C_ALU;
      d_alu_op  = 2'b00;
      d_alu_src = 1'b1;
      unique case (op)
         5'b00000: d_cls = C_LOAD;
         5'b01000: d_cls = C_STORE;
         5'b11000: begin
            d_cls     = C_BRANCH;
            d_alu_op  = 2'b01;
            d_alu_src = 1'b0;
         end
         5'b11001, 5'b11011, 5'b00101, 5'b01101: begin
         end
         5'b00100: d_alu_op = 2'b11;
         5'b01100: begin
            d_alu_op  = 2'b10;
            d_alu_src = 1'b0;
         end
         default: legal = 1'b0;
      endcase
   end

   // Without the M extension an R-type with funct7[0] set is a plain ALU op.
   assign d_mul = (M_EXT != 0) && (op == 5'b01100) && funct7_0;

   always_comb begin
      state_d = state_q;
      req_c   = 1'b0;
      we_c    = 1'b0;
      irw_c   = 1'b0;
      pcw_c   = 1'b0;
      br_c    = 1'b0;
      rw_c    = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            req_c = 1'b1;
            if (mem_ready) begin
               irw_c   = 1'b1;
               pcw_c   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!legal)
               state_d = S_TRAP;
            else if (d_mul)
               state_d = S_MULWAIT;
            else
               state_d = S_EXEC;
         end
         S_EXEC: begin
            unique case (cls_q)
               C_BRANCH: begin
                  br_c    = 1'b1;
                  state_d = S_FETCH;
               end
               C_LOAD, C_STORE: state_d = S_MEM;
               default: state_d = S_WB;
            endcase
         end
         S_MEM: begin
            req_c = 1'b1;
            we_c  = (cls_q == C_STORE);
            if (mem_ready)
               state_d = (cls_q == C_LOAD) ? S_WB : S_FETCH;
         end
         S_WB: begin
            rw_c    = 1'b1;
            state_d = S_FETCH;
         end
         S_MULWAIT: begin
            if (cnt_q == 4'd0)
               state_d = S_WB;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cls_q     <= C_ALU;
         alu_op_q  <= 2'b00;
         alu_src_q <= 1'b0;
         mtr_q     <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == S_TRAP);
         if (state_q == S_DECODE && legal) begin
            cls_q     <= d_cls;
            alu_op_q  <= d_alu_op;
            alu_src_q <= d_alu_src;
            mtr_q     <= (d_cls == C_LOAD);
         end
         // Loaded with L-1 so that MULWAIT lasts exactly L cycles.
         if (state_q == S_DECODE && legal && d_mul)
            cnt_q <= 4'(MUL_LATENCY - 1);
         else if (state_q == S_MULWAIT && cnt_q != 4'd0)
            cnt_q <= cnt_q - 4'd1;
      end
   end

   // Reset forces FETCH asynchronously; strobes are masked while it is held.
   assign mem_req    = req_c & ~rst;
   assign mem_we     = we_c & ~rst;
   assign ir_write   = irw_c & ~rst;
   assign pc_write   = pcw_c & ~rst;
   assign branch     = br_c & ~rst;
   assign reg_write  = rw_c & ~rst;
   assign alu_op     = alu_op_q;
   assign alu_src    = alu_src_q;
   assign mem_to_reg = mtr_q;
   assign state      = state_q;
   assign illegal    = illegal_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: an instruction-level planner
// builds the expected per-cycle trace and the drive values, then replays it.
module tb_multicycle_control_unit;

   localparam int LAT = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_v = 2'b11;
   logic [4:0] op_v [2];
   logic [1:0] f7_v;
   logic [1:0] rdy_v;
   logic [13:0] obs [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic mem_req, mem_we, ir_write, pc_write, branch;
      logic mem_to_reg, alu_src, reg_write, illegal;
      logic [1:0] alu_op;
      logic [2:0] state;

      multicycle_control_unit #(
         .M_EXT      (g == 0 ? 1 : 0),
         .MUL_LATENCY(LAT)
      ) dut (
         .clk       (clk),
         .rst       (rst_v[g]),
         .op        (op_v[g]),
         .funct7_0  (f7_v[g]),
         .mem_ready (rdy_v[g]),
         .mem_req   (mem_req),
         .mem_we    (mem_we),
         .ir_write  (ir_write),
         .pc_write  (pc_write),
         .branch    (branch),
         .mem_to_reg(mem_to_reg),
         .alu_src   (alu_src),
         .reg_write (reg_write),
         .alu_op    (alu_op),
         .state     (state),
         .illegal   (illegal)
      );

      assign obs[g] = {state, mem_req, mem_we, ir_write, pc_write,
                       branch, reg_write, illegal,
                       alu_op, alu_src, mem_to_reg};
   end

   typedef struct {
      logic        rst;
      logic [4:0]  op;
      logic        f7;
      logic        rdy;
      logic [13:0] exp;
   } rec_t;

   rec_t q[$];
   logic [3:0] cur_ctl;
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [13:0] got,
                      input logic [13:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b", tag, got, want);
      end
   endtask

   function automatic bit is_legal(input logic [4:0] o);
      return o inside {5'b00000, 5'b01000, 5'b11000, 5'b11001, 5'b11011,
                       5'b00100, 5'b01100, 5'b00101, 5'b01101};
   endfunction

   // sb = {mem_req, mem_we, ir_write, pc_write, branch, reg_write}
   function automatic void push(input int st, input bit rdy,
                                input logic [5:0] sb, input bit il,
                                input logic [4:0] o, input bit f);
      rec_t r;
      r.rst = 1'b0;
      r.op  = o;
      r.f7  = f;
      r.rdy = rdy;
      r.exp = {3'(st), sb, il, cur_ctl};
      q.push_back(r);
   endfunction

   function automatic void push_rst();
      rec_t r;
      r.rst = 1'b1;
      r.op  = 5'($urandom);
      r.f7  = 1'($urandom);
      r.rdy = 1'($urandom);
      r.exp = '0;
      cur_ctl = 4'b0;
      q.push_back(r);
   endfunction

   function automatic void junk(input int st, input logic [5:0] sb,
                                input bit il);
      push(st, 1'($urandom), sb, il, 5'($urandom), 1'($urandom));
   endfunction

   // Plan one instruction: fw fetch stalls, mw memory stalls, optional
   // reset injected somewhere inside the instruction.
   function automatic void plan(input bit m_ext, input logic [4:0] o,
                                input bit f, input int fw, input int mw,
                                input bit cut);
      int n0 = q.size();
      bit ld = (o == 5'b00000);
      bit st = (o == 5'b01000);
      logic [1:0] aop;
      bit asrc;
      for (int i = 0; i < fw; i++)
         push(0, 1'b0, 6'b100000, 1'b0, 5'($urandom), 1'($urandom));
      push(0, 1'b1, 6'b101100, 1'b0, 5'($urandom), 1'($urandom));
      push(1, 1'($urandom), 6'b0, 1'b0, o, f);
      if (!is_legal(o)) begin
         for (int i = 0; i < 20; i++) junk(6, 6'b0, 1'b1);
         push_rst();
         return;
      end
      aop  = (o == 5'b11000) ? 2'b01 :
             (o == 5'b01100) ? 2'b10 :
             (o == 5'b00100) ? 2'b11 : 2'b00;
      asrc = !(o == 5'b11000 || o == 5'b01100);
      cur_ctl = {aop, asrc, ld};
      if (m_ext && o == 5'b01100 && f) begin
         for (int i = 0; i < LAT; i++) junk(5, 6'b0, 1'b0);
         junk(4, 6'b000001, 1'b0);
      end else if (o == 5'b11000) begin
         junk(2, 6'b000010, 1'b0);
      end else if (ld || st) begin
         junk(2, 6'b0, 1'b0);
         for (int i = 0; i < mw; i++)
            push(3, 1'b0, {1'b1, st, 4'b0}, 1'b0, 5'($urandom),
                 1'($urandom));
         push(3, 1'b1, {1'b1, st, 4'b0}, 1'b0, 5'($urandom), 1'($urandom));
         if (ld) junk(4, 6'b000001, 1'b0);
      end else begin
         junk(2, 6'b0, 1'b0);
         junk(4, 6'b000001, 1'b0);
      end
      if (cut && q.size() - n0 >= 2) begin
         int k = $urandom_range(n0 + 1, q.size() - 1);
         while (q.size() > k) void'(q.pop_back());
         push_rst();
      end
   endfunction

   function automatic logic [4:0] rand_op();
      logic [4:0] o;
      int r = $urandom_range(0, 11);
      logic [4:0] lo [9] = '{5'b00000, 5'b01000, 5'b11000, 5'b11001,
                             5'b11011, 5'b00100, 5'b01100, 5'b00101,
                             5'b01101};
      if (r < 9) return lo[r];
      if (r == 9) return 5'b11100;
      do o = 5'($urandom); while (is_legal(o));
      return o;
   endfunction

   function automatic void rand_plan(input bit m_ext);
      plan(m_ext, rand_op(), 1'($urandom), $urandom_range(0, 2),
           $urandom_range(0, 3), $urandom_range(0, 7) == 0);
   endfunction

   task automatic run(input int sel);
      int cyc = 0;
      while (q.size() > 0) begin
         rec_t r = q.pop_front();
         @(negedge clk);
         rst_v[sel] = r.rst;
         op_v[sel]  = r.op;
         f7_v[sel]  = r.f7;
         rdy_v[sel] = r.rdy;
         #1;
         chk($sformatf("dut%0d cyc%0d", sel, cyc), obs[sel], r.exp);
         cyc++;
      end
   endtask

   initial begin
      op_v[0] = '0;
      op_v[1] = '0;
      f7_v    = '0;
      rdy_v   = '0;
      cur_ctl = '0;

      push_rst();
      plan(1'b1, 5'b00100, 1'b0, 0, 0, 1'b0);
      plan(1'b1, 5'b00000, 1'b0, 1, 3, 1'b0);
      plan(1'b1, 5'b01000, 1'b1, 0, 2, 1'b0);
      plan(1'b1, 5'b01100, 1'b1, 0, 0, 1'b0);
      plan(1'b1, 5'b11000, 1'b0, 0, 0, 1'b0);
      plan(1'b1, 5'b01100, 1'b0, 0, 0, 1'b0);
      plan(1'b1, 5'b11100, 1'b0, 0, 0, 1'b0);
      for (int i = 0; i < 150; i++) rand_plan(1'b1);
      run(0);
      @(negedge clk);
      rst_v[0] = 1'b1;

      cur_ctl = '0;
      push_rst();
      plan(1'b0, 5'b01100, 1'b1, 0, 0, 1'b0);
      plan(1'b0, 5'b01101, 1'b1, 0, 0, 1'b0);
      for (int i = 0; i < 60; i++) rand_plan(1'b0);
      run(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
